cpu_clock_control: RTL
======================

Name: cpu_clock_control

Overview:
- Sits directly downstream of the clock divider and consumes its slow square wave `clkout`.
- Converts each rising edge of the slow wave into a single-`clkin`-cycle CPU enable pulse. The CPU core runs on the fast clock with this enable; it never runs on a derived clock.
- Adds a run/stop switch, a debounced single-step button and CPU-halt handling, so the CPU can be free-run at the divided rate, stepped by hand, or stopped.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive `clkin` cycles the synced step button must hold a new level before it is accepted (10 ms at 50 MHz).
- CNT_W, 16, width of the enabled-cycle counter.

Ports:
- clkin  input  1  fast system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- slow_clk  input  1  divided square wave from the clock divider; treated as asynchronous.
- run_sw  input  1  raw run switch level: 1 = free-run, 0 = stopped.
- step_btn  input  1  raw push button, active-high, bouncy.
- halt  input  1  CPU halt request, level, synchronous to `clkin`.
- cpu_en  output  1  one-cycle CPU clock-enable pulse (registered).
- running  output  1  high while in RUN.
- halted  output  1  high while in HALT.
- cycle_count  output  CNT_W  number of `cpu_en` pulses issued.

Behaviour:
- Reset: the reset is asynchronous and active-high, and clears all state on assertion. Reset values:
  - `cpu_en`=0, `running`=0, `halted`=0, `cycle_count`=0.
  - FSM=IDLE.
  - Synchronizer and debounce registers=0; debounce counter=0.
- Reset mid-pulse kills `cpu_en` immediately.
- `slow_clk` path:
  - 2-FF synchronizer s1→s2, plus history FF s3.
  - `tick` = s2 & ~s3, which is exactly one cycle per slow rising edge.
  - Falling edges of `slow_clk` are ignored.
- `run_sw` path: 2-FF synchronizer to `run_s`. No debounce.
- `step_btn` path:
  - 2-FF synchronizer to `btn_s`.
  - Debounce counter resets to 0 whenever `btn_s` equals the debounced level `btn_db`.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, `btn_db` takes the value of `btn_s` and the counter clears.
  - `step_press` = one-cycle rising edge of `btn_db`.
- FSM states and transitions. Priority within a state is listed top-down.
  - IDLE (`cpu_en`=0):
    - `halt`=1 → HALT.
    - `run_s`=1 → RUN.
    - `step_press` → STEP.
  - RUN:
    - `halt`=1 → HALT, and no pulse that cycle even if `tick`=1.
    - `run_s`=0 → IDLE, with no pulse that cycle.
    - Otherwise `cpu_en` is the registered `tick`.
    - `step_press` is ignored.
  - STEP:
    - `halt`=1 → HALT.
    - On `tick`: one pulse, then → IDLE.
    - `step_press` is ignored while waiting.
    - `run_s` rising while in STEP: finish the step first (→ IDLE), then IDLE moves to RUN on the next cycle.
  - HALT (`cpu_en`=0, `halted`=1): exit only via reset. `run_sw`, `step_btn` and `tick` are ignored.
- Latency:
  - `slow_clk` rising before `clkin` edge 1 → `tick` high after edge 2 → `cpu_en` high for exactly the cycle after edge 3.
  - Minimum spacing between pulses equals the slow period.
- `running` and `halted` are registered and reflect the FSM state one cycle after the transition edge.
- `cycle_count` increments by 1 on the same edge that sets `cpu_en`=1 and wraps from 2^CNT_W−1 to 0. It is never cleared except by reset.

Test Plan (bench uses DEBOUNCE_CYCLES=4, `slow_clk` period 20 `clkin` cycles):
- Free-run: reset, then `run_sw`=1 for 5 slow periods → exactly 5 `cpu_en` pulses, each 1 cycle wide, each 3 `clkin` edges after its `slow_clk` rise; `cycle_count`=5; `running`=1.
- Bouncy step: `run_sw`=0; `step_btn` toggles every cycle for 3 cycles, then holds 1 for 10 cycles → exactly 1 `step_press` and exactly 1 `cpu_en`, on the next `tick`; FSM back in IDLE; holding the button longer gives no further pulses.
- Stop mid-run: `run_sw` 1→0 while a `tick` is pending → no pulse on or after the synced fall edge; `running`=0; a later `step_press` yields 1 pulse.
- Halt priority: in RUN, assert `halt` on the same cycle `tick`=1 → `cpu_en` stays 0; `halted`=1; toggling `run_sw` and `step_btn` produces 0 pulses until reset.
- Counter wrap: CNT_W=4, run 17 slow periods → `cycle_count` goes 15→0→1.
- Async reset: assert `reset` in the middle of a `cpu_en` pulse → `cpu_en` drops before the next clock edge; all outputs 0; FSM IDLE.

Source files
------------

// File: rtl/cpu_clock_control.sv
// CPU clock-enable generator: turns the rising edges of the divided slow wave
// into single-clkin-cycle enable pulses, gated by a run/stop switch, a
// debounced single-step button and a sticky CPU halt.
module cpu_clock_control #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 16
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  // Enabled-cycle counter rolls over silently; it is a free-running tally.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  // Slow-wave synchronizer (p0, p1) plus history stage p2 for edge detection.
  logic slow_p0, slow_p1, slow_p2;
  // Run switch and step button synchronizers.
  logic run_p0, run_p1;
  logic btn_p0, btn_p1;
  // Debounce state.
  logic            btn_db, btn_db_q;
  logic [DB_W-1:0] db_cnt;

  logic   tick, run_s, btn_s, step_press;
  state_t state, state_nxt;
  logic   pulse_nxt;

  // ---- stage p0/p1/p2: input synchronization ----
  // Bring the asynchronous slow wave, run switch and button into clkin.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      slow_p0 <= 1'b0;
      slow_p1 <= 1'b0;
      slow_p2 <= 1'b0;
      run_p0  <= 1'b0;
      run_p1  <= 1'b0;
      btn_p0  <= 1'b0;
      btn_p1  <= 1'b0;
    end else begin
      slow_p0 <= slow_clk;
      slow_p1 <= slow_p0;
      slow_p2 <= slow_p1;
      run_p0  <= run_sw;
      run_p1  <= run_p0;
      btn_p0  <= step_btn;
      btn_p1  <= btn_p0;
    end
  end

  // Only rising edges of the slow wave produce a tick; falling edges are dropped.
  assign tick  = slow_p1 & ~slow_p2;
  assign run_s = run_p1;
  assign btn_s = btn_p1;

  // ---- debounce: accept a new button level only after it holds steadily ----
  // Counter restarts whenever the synced level agrees with the accepted level.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign step_press = btn_db & ~btn_db_q;

  // ---- control FSM ----
  // State register.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; halt always wins and HALT is left only through reset.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (halt)            state_nxt = HALT;
        else if (run_s)      state_nxt = RUN;
        else if (step_press) state_nxt = STEP;
      end
      RUN: begin
        if (halt)        state_nxt = HALT;
        else if (!run_s) state_nxt = IDLE;
      end
      STEP: begin
        if (halt)      state_nxt = HALT;
        else if (tick) state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Pulse decision: a tick passes only in RUN with the switch still on, or
  // as the single pending step; halt suppresses a coincident tick.
  always_comb begin
    pulse_nxt = 1'b0;
    unique case (state)
      RUN:     pulse_nxt = tick & run_s & ~halt;
      STEP:    pulse_nxt = tick & ~halt;
      default: pulse_nxt = 1'b0;
    endcase
  end

  // ---- output registers ----
  // Enable, status flags and the pulse tally, all updated together.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      cpu_en      <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      cpu_en  <= pulse_nxt;
      running <= (state == RUN);
      halted  <= (state == HALT);
      if (pulse_nxt) cycle_count <= wrap_inc(cycle_count);
    end
  end

endmodule
